// File: rtl/hdc_classify_seq.sv
// rtl/hdc_classify_seq.sv - word-serial HDC ham/spam classification sequencer (optional HDC_PERF_CNT_EN adds perf_cycles)
module hdc_classify_seq #(
  parameter int DIM        = 10000,
  parameter int WORD_W     = 32,
  parameter int MAX_LENGTH = 160,
  localparam int NUM_WORDS = (DIM + WORD_W - 1) / WORD_W,
  localparam int WIDX_W    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1,
  localparam int CNT_W     = $clog2(DIM + 1),
  localparam int POP_W     = $clog2(WORD_W + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_data,
  input  logic              in_last,
  output logic [5:0]        dp_sym,
  output logic [WIDX_W-1:0] dp_word,
  output logic              dp_clr,
  output logic              dp_acc_en,
  output logic              dp_thr_en,
  output logic              dp_cmp_en,
  output logic [7:0]        dp_len,
  input  logic [POP_W-1:0]  dp_ham_pop,
  input  logic [POP_W-1:0]  dp_spam_pop,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [1:0]        result,
  output logic              busy
`ifdef HDC_PERF_CNT_EN
  ,
  output logic [31:0]       perf_cycles
`endif
);

  typedef enum logic [2:0] {
    IDLE, CLEAR, ACCUM, WAIT_CHAR, THRESH, COMPARE, DONE
  } state_t;

  localparam logic [WIDX_W-1:0] LAST_WORD = WIDX_W'(NUM_WORDS - 1);
  localparam logic [CNT_W:0]    DIM_SAT   = (CNT_W + 1)'(DIM);

  state_t            state_q, state_d;
  logic [WIDX_W-1:0] word_q, word_d;
  logic [5:0]        sym_q, sym_d;
  logic              last_q, last_d;
  logic [7:0]        len_q, len_d;
  logic              clr_q, clr_d, acc_q, acc_d, thr_q, thr_d, cmp_q, cmp_d;
  logic              cmp_dly_q, cmp_dly_d;
  logic              in_ready_q, in_ready_d;
  logic              res_valid_q, res_valid_d;
  logic [1:0]        result_q, result_d;
  logic              busy_q, busy_d;
  logic [CNT_W-1:0]  cnt_ham_q, cnt_ham_d, cnt_spam_q, cnt_spam_d;
  logic [CNT_W:0]    ham_sum, spam_sum;
  logic [7:0]        tok_full;
  logic [5:0]        tok_sym;
  logic              accept, word_last;

  // Map the incoming ASCII byte to its item-memory symbol index
  always_comb begin
    tok_full = 8'd0;
    if (in_data >= 8'h41 && in_data <= 8'h5a) begin
      tok_full = in_data - 8'd54;
    end else if (in_data >= 8'h61 && in_data <= 8'h7a) begin
      tok_full = in_data - 8'd86;
    end else if (in_data >= 8'h30 && in_data <= 8'h39) begin
      tok_full = in_data - 8'd47;
    end
    tok_sym = tok_full[5:0];
  end

  assign accept    = in_valid & in_ready_q;
  assign word_last = (word_q == LAST_WORD);
  assign ham_sum   = {1'b0, cnt_ham_q} + (CNT_W + 1)'(dp_ham_pop);
  assign spam_sum  = {1'b0, cnt_spam_q} + (CNT_W + 1)'(dp_spam_pop);

  // Next-state and next-output decode; every output is registered alongside the state
  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    sym_d       = sym_q;
    last_d      = last_q;
    len_d       = len_q;
    clr_d       = 1'b0;
    acc_d       = 1'b0;
    thr_d       = 1'b0;
    cmp_d       = 1'b0;
    cmp_dly_d   = cmp_q;
    in_ready_d  = 1'b0;
    res_valid_d = res_valid_q;
    result_d    = result_q;
    cnt_ham_d   = cnt_ham_q;
    cnt_spam_d  = cnt_spam_q;
    case (state_q)
      IDLE: begin
        in_ready_d = 1'b1;
        if (accept) begin
          sym_d      = tok_sym;
          last_d     = in_last;
          len_d      = 8'd1;
          word_d     = '0;
          clr_d      = 1'b1;
          in_ready_d = 1'b0;
          state_d    = CLEAR;
        end
      end
      CLEAR: begin
        if (word_last) begin
          word_d  = '0;
          acc_d   = 1'b1;
          state_d = ACCUM;
        end else begin
          word_d = word_q + 1'b1;
          clr_d  = 1'b1;
        end
      end
      ACCUM: begin
        if (word_last) begin
          word_d = '0;
          if (last_q) begin
            thr_d   = 1'b1;
            state_d = THRESH;
          end else begin
            in_ready_d = 1'b1;
            state_d    = WAIT_CHAR;
          end
        end else begin
          word_d = word_q + 1'b1;
          acc_d  = 1'b1;
        end
      end
      WAIT_CHAR: begin
        in_ready_d = 1'b1;
        if (accept) begin
          if (len_q < 8'(MAX_LENGTH)) begin
            sym_d      = tok_sym;
            last_d     = in_last;
            len_d      = len_q + 8'd1;
            word_d     = '0;
            acc_d      = 1'b1;
            in_ready_d = 1'b0;
            state_d    = ACCUM;
          end else if (in_last) begin
            // Message overran the bundle limit; its tail is consumed but not bundled
            word_d     = '0;
            thr_d      = 1'b1;
            in_ready_d = 1'b0;
            state_d    = THRESH;
          end
        end
      end
      THRESH: begin
        cnt_ham_d  = '0;
        cnt_spam_d = '0;
        if (word_last) begin
          word_d  = '0;
          cmp_d   = 1'b1;
          state_d = COMPARE;
        end else begin
          word_d = word_q + 1'b1;
          thr_d  = 1'b1;
        end
      end
      COMPARE: begin
        // Popcounts arrive one cycle after their compare strobe
        if (cmp_dly_q) begin
          cnt_ham_d  = (ham_sum > DIM_SAT) ? CNT_W'(DIM) : ham_sum[CNT_W-1:0];
          cnt_spam_d = (spam_sum > DIM_SAT) ? CNT_W'(DIM) : spam_sum[CNT_W-1:0];
        end
        if (cmp_q) begin
          if (word_last) begin
            word_d = '0;
          end else begin
            word_d = word_q + 1'b1;
            cmp_d  = 1'b1;
          end
        end else begin
          res_valid_d = 1'b1;
          if (cnt_ham_d > cnt_spam_d) begin
            result_d = 2'b00;
          end else if (cnt_ham_d < cnt_spam_d) begin
            result_d = 2'b01;
          end else begin
            result_d = 2'b11;
          end
          state_d = DONE;
        end
      end
      DONE: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      word_q      <= '0;
      sym_q       <= '0;
      last_q      <= 1'b0;
      len_q       <= '0;
      clr_q       <= 1'b0;
      acc_q       <= 1'b0;
      thr_q       <= 1'b0;
      cmp_q       <= 1'b0;
      cmp_dly_q   <= 1'b0;
      in_ready_q  <= 1'b0;
      res_valid_q <= 1'b0;
      result_q    <= 2'b00;
      busy_q      <= 1'b0;
      cnt_ham_q   <= '0;
      cnt_spam_q  <= '0;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      sym_q       <= sym_d;
      last_q      <= last_d;
      len_q       <= len_d;
      clr_q       <= clr_d;
      acc_q       <= acc_d;
      thr_q       <= thr_d;
      cmp_q       <= cmp_d;
      cmp_dly_q   <= cmp_dly_d;
      in_ready_q  <= in_ready_d;
      res_valid_q <= res_valid_d;
      result_q    <= result_d;
      busy_q      <= busy_d;
      cnt_ham_q   <= cnt_ham_d;
      cnt_spam_q  <= cnt_spam_d;
    end
  end

`ifdef HDC_PERF_CNT_EN
  logic [31:0] perf_q;

  // Count busy cycles of one classification, frozen once the result is posted
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_q <= '0;
    end else if (state_q == IDLE && state_d == CLEAR) begin
      perf_q <= '0;
    end else if (state_q != IDLE && state_q != DONE) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_cycles = perf_q;
`endif

  assign in_ready  = in_ready_q;
  assign dp_sym    = sym_q;
  assign dp_word   = word_q;
  assign dp_clr    = clr_q;
  assign dp_acc_en = acc_q;
  assign dp_thr_en = thr_q;
  assign dp_cmp_en = cmp_q;
  assign dp_len    = len_q;
  assign res_valid = res_valid_q;
  assign result    = result_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_hdc_classify_seq.sv
// tb/tb_hdc_classify_seq.sv - scoreboard testbench for hdc_classify_seq
module tb_hdc_classify_seq;
  localparam int DIM = 64;
  localparam int WORD_W = 32;
  localparam int MAX_LENGTH = 4;
  localparam int NW = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [7:0] in_data = 8'd0;
  logic in_last = 1'b0;
  logic [5:0] dp_sym;
  logic [0:0] dp_word;
  logic dp_clr, dp_acc_en, dp_thr_en, dp_cmp_en;
  logic [7:0] dp_len;
  logic [5:0] dp_ham_pop, dp_spam_pop;
  logic res_valid;
  logic res_ready = 1'b0;
  logic [1:0] result;
  logic busy;
`ifdef HDC_PERF_CNT_EN
  logic [31:0] perf_cycles;
`endif

  always #5 clk = ~clk;

  hdc_classify_seq #(.DIM(DIM), .WORD_W(WORD_W), .MAX_LENGTH(MAX_LENGTH)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .dp_sym(dp_sym), .dp_word(dp_word), .dp_clr(dp_clr), .dp_acc_en(dp_acc_en),
    .dp_thr_en(dp_thr_en), .dp_cmp_en(dp_cmp_en), .dp_len(dp_len),
    .dp_ham_pop(dp_ham_pop), .dp_spam_pop(dp_spam_pop),
    .res_valid(res_valid), .res_ready(res_ready), .result(result), .busy(busy)
`ifdef HDC_PERF_CNT_EN
    , .perf_cycles(perf_cycles)
`endif
  );

  // Datapath stand-in: popcounts are only meaningful the cycle after a compare strobe
  int ham_val = 0;
  int spam_val = 0;
  logic cmp_prev = 1'b0;
  always @(posedge clk) cmp_prev <= dp_cmp_en;
  assign dp_ham_pop  = cmp_prev ? 6'(ham_val) : 6'd31;
  assign dp_spam_pop = cmp_prev ? 6'(spam_val) : 6'd17;

  int compared = 0;
  int mismatched = 0;
  logic [1:0] sb[$];
  logic [7:0] msg[$];
  int syms[$];
  int exp_syms[$];
  int n_clr, n_acc, n_thr, n_cmp, n_accepted, last_acc_cyc, res_cyc;
  bit ready_in_acc, onehot_bad, timed_out, aborted;
  logic [1:0] res_seen;
  logic [1:0] exp_res;

  function automatic logic [1:0] model(input int h, input int s);
    int ch, cs;
    ch = h * NW; if (ch > DIM) ch = DIM;
    cs = s * NW; if (cs > DIM) cs = DIM;
    if (ch > cs) return 2'b00;
    if (ch < cs) return 2'b01;
    return 2'b11;
  endfunction

  // Drive msg back to back and trace the datapath strobes until a result (or compare, if aborting)
  task automatic run_msg(input bit abort_on_cmp);
    int idx;
    idx = 0;
    n_clr = 0; n_acc = 0; n_thr = 0; n_cmp = 0; n_accepted = 0;
    last_acc_cyc = 0; res_cyc = 0;
    ready_in_acc = 0; onehot_bad = 0; timed_out = 1; aborted = 0;
    syms.delete();
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      if (int'(dp_clr) + int'(dp_acc_en) + int'(dp_thr_en) + int'(dp_cmp_en) > 1) onehot_bad = 1;
      if (dp_clr) n_clr++;
      if (dp_thr_en) n_thr++;
      if (dp_cmp_en) n_cmp++;
      if (dp_acc_en) begin
        n_acc++;
        if (in_ready) ready_in_acc = 1;
        if (dp_word == 1'b0) syms.push_back(int'(dp_sym));
      end
      if (abort_on_cmp && dp_cmp_en) begin
        aborted = 1; timed_out = 0;
        break;
      end
      if (res_valid) begin
        res_seen = result; res_cyc = cyc; timed_out = 0;
        break;
      end
      if (idx < msg.size()) begin
        in_valid = 1'b1;
        in_data = msg[idx];
        in_last = (idx == msg.size() - 1);
        if (in_ready) begin
          idx++; n_accepted++; last_acc_cyc = cyc;
        end
      end else begin
        in_valid = 1'b0; in_last = 1'b0;
      end
    end
    in_valid = 1'b0; in_last = 1'b0;
    compared++;
    if (timed_out) begin
      mismatched++;
      $display("FAIL run_timeout: no DUT response within 400 cycles, required one");
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    compared++;
    if ({in_ready, busy, res_valid, dp_clr, dp_acc_en, dp_thr_en, dp_cmp_en} !== 7'd0) begin
      mismatched++;
      $display("FAIL reset_ctrl: got %b required 0000000",
               {in_ready, busy, res_valid, dp_clr, dp_acc_en, dp_thr_en, dp_cmp_en});
    end
    compared++;
    if ({dp_sym, dp_word, dp_len, result} !== 17'd0) begin
      mismatched++;
      $display("FAIL reset_data: sym=%0d word=%0d len=%0d result=%0d required all 0", dp_sym, dp_word, dp_len, result);
    end
    reset = 1'b0;
    @(negedge clk);
    compared++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL idle_ready: in_ready=%b busy=%b required 1/0", in_ready, busy);
    end
  endtask

  task automatic take_result(input string name);
    if (timed_out) return;
    exp_res = sb.pop_front();
    compared++;
    if (res_seen !== exp_res) begin
      mismatched++;
      $display("FAIL %s_result: got %b required %b", name, res_seen, exp_res);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    compared++;
    if (res_valid !== 1'b0 || in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL %s_handshake: res_valid=%b in_ready=%b required 0/1", name, res_valid, in_ready);
    end
  endtask

  task automatic test_single;
    msg = '{8'h41};
    ham_val = 3; spam_val = 5;
    sb.push_back(model(3, 5));
    run_msg(0);
    compared++;
    if (n_clr != 2 || n_acc != 2 || n_thr != 2 || n_cmp != 2) begin
      mismatched++;
      $display("FAIL single_phases: clr=%0d acc=%0d thr=%0d cmp=%0d required 2/2/2/2", n_clr, n_acc, n_thr, n_cmp);
    end
    compared++;
    if (syms.size() != 1 || syms[0] != 11 || dp_len !== 8'd1) begin
      mismatched++;
      $display("FAIL single_sym: nsym=%0d len=%0d required one symbol 11, len 1", syms.size(), dp_len);
    end
    compared++;
    if (res_cyc - last_acc_cyc != 10) begin
      mismatched++;
      $display("FAIL single_latency: got %0d required 10", res_cyc - last_acc_cyc);
    end
`ifdef HDC_PERF_CNT_EN
    compared++;
    if (perf_cycles !== 32'd9) begin
      mismatched++;
      $display("FAIL perf_cycles: got %0d required 9", perf_cycles);
    end
`endif
    compared++;
    if (onehot_bad) begin
      mismatched++;
      $display("FAIL single_onehot: got overlapping strobes required at most one");
    end
    take_result("single");
  endtask

  task automatic test_multi;
    msg = '{8'h7a, 8'h39, 8'h3f};
    ham_val = 7; spam_val = 2;
    sb.push_back(model(7, 2));
    run_msg(0);
    exp_syms = '{36, 10, 0};
    compared++;
    if (syms.size() != 3) begin
      mismatched++;
      $display("FAIL multi_nsym: got %0d required 3", syms.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        compared++;
        if (syms[i] != exp_syms[i]) begin
          mismatched++;
          $display("FAIL multi_sym%0d: got %0d required %0d", i, syms[i], exp_syms[i]);
        end
      end
    end
    compared++;
    if (ready_in_acc || n_acc != 6 || dp_len !== 8'd3) begin
      mismatched++;
      $display("FAIL multi_accum: ready_in_acc=%0b acc=%0d len=%0d required 0/6/3", ready_in_acc, n_acc, dp_len);
    end
    take_result("multi");
  endtask

  task automatic test_tie_hold;
    msg = '{8'h51};
    ham_val = 4; spam_val = 4;
    sb.push_back(model(4, 4));
    run_msg(0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      compared++;
      if (res_valid !== 1'b1 || result !== res_seen || in_ready !== 1'b0) begin
        mismatched++;
        $display("FAIL hold_%0d: res_valid=%b result=%b in_ready=%b required 1/%b/0", i, res_valid, result, in_ready, res_seen);
      end
    end
    take_result("tie");
  endtask

  task automatic test_maxlen;
    msg = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66};
    ham_val = 1; spam_val = 2;
    sb.push_back(model(1, 2));
    run_msg(0);
    exp_syms = '{11, 12, 13, 14};
    compared++;
    if (n_acc != 8 || n_accepted != 6 || dp_len !== 8'd4 || syms.size() != 4) begin
      mismatched++;
      $display("FAIL maxlen_counts: acc=%0d accepted=%0d len=%0d nsym=%0d required 8/6/4/4", n_acc, n_accepted, dp_len, syms.size());
    end else begin
      compared++;
      if (syms[3] != exp_syms[3] || syms[0] != exp_syms[0]) begin
        mismatched++;
        $display("FAIL maxlen_sym: got %0d,%0d required 11,14", syms[0], syms[3]);
      end
    end
    take_result("maxlen");
  endtask

  task automatic test_reset_mid;
    bit leak;
    msg = '{8'h42};
    ham_val = 2; spam_val = 2;
    run_msg(1);
    compared++;
    if (!aborted) begin
      mismatched++;
      $display("FAIL mid_reach_cmp: got no compare phase required one");
    end
    reset = 1'b1;
    @(negedge clk);
    compared++;
    if ({in_ready, busy, res_valid, dp_clr, dp_acc_en, dp_thr_en, dp_cmp_en} !== 7'd0 ||
        {dp_sym, dp_word, dp_len, result} !== 17'd0) begin
      mismatched++;
      $display("FAIL mid_reset_state: ctrl=%b sym=%0d len=%0d result=%b required all 0",
               {in_ready, busy, res_valid, dp_clr, dp_acc_en, dp_thr_en, dp_cmp_en}, dp_sym, dp_len, result);
    end
    reset = 1'b0;
    leak = 0;
    repeat (12) begin
      @(negedge clk);
      if (res_valid) leak = 1;
    end
    compared++;
    if (leak || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL mid_no_result: res_valid_seen=%b busy=%b required 0/0", leak, busy);
    end
    msg = '{8'h37};
    ham_val = 1; spam_val = 9;
    sb.push_back(model(1, 9));
    run_msg(0);
    take_result("after_reset");
  endtask

  task automatic test_back_to_back;
    msg = '{8'h48, 8'h69};
    ham_val = 10; spam_val = 10;
    sb.push_back(model(10, 10));
    run_msg(0);
    take_result("b2b_first");
    msg = '{8'h78};
    ham_val = 32; spam_val = 5;
    sb.push_back(model(32, 5));
    run_msg(0);
    take_result("b2b_second");
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi();
    test_tie_hold();
    test_maxlen();
    test_reset_mid();
    test_back_to_back();
    compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL scoreboard_drain: %0d results outstanding required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
